// File: rtl/operand_mux_pipe.sv
// Operand select/extend stage feeding a 2-entry skid buffer (main + skid).
// Illegal selects still flow through as zero data and are tallied in SelErr/ErrCount.
module operand_mux_pipe #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int IMM_IDX = 2,
    parameter int IMMW    = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NSRC*WIDTH-1:0] SrcData,
    input  logic [SELW-1:0]       Sel,
    input  logic                  ExtMode,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [WIDTH-1:0]      OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    input  logic                  Flush,
    input  logic                  ErrClr,
    output logic                  SelErr,
    output logic [7:0]            ErrCount
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} bufState;

    bufState          state, stateNext;
    logic [WIDTH-1:0] srcArr [NSRC];
    logic [WIDTH-1:0] immSrc, immExt, selData;
    logic [WIDTH-1:0] mainData, skidData;
    logic             selLegal, accept, xfer, errHit;
    logic             loadMain, loadSkid, moveSkid;
    logic             inReadyQ, outValidQ;

    for (genvar g = 0; g < NSRC; g++) begin : gSrc
        assign srcArr[g] = SrcData[g*WIDTH +: WIDTH];
    end

    assign immSrc = srcArr[IMM_IDX];

    if (IMMW < WIDTH) begin : gExt
        assign immExt = {{(WIDTH-IMMW){ExtMode & immSrc[IMMW-1]}}, immSrc[IMMW-1:0]};
    end else begin : gNoExt
        assign immExt = immSrc;
    end

    // Out-of-range selects leave selData at zero rather than reusing a stale value.
    always_comb begin
        selData  = '0;
        selLegal = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (Sel == SELW'(k)) begin
                selLegal = 1'b1;
                selData  = (k == IMM_IDX) ? immExt : srcArr[k];
            end
        end
    end

    assign accept = InValid & inReadyQ;
    assign xfer   = outValidQ & OutReady;
    assign errHit = accept & ~selLegal & ~Flush;

    always_comb begin
        stateNext = state;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext = ONE;
                    loadMain  = 1'b1;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (accept && xfer) begin
                    loadMain  = 1'b1;
                end else if (xfer) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    stateNext = ONE;
                    moveSkid  = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        if (Flush) begin
            stateNext = EMPTY;
            loadMain  = 1'b0;
            loadSkid  = 1'b0;
            moveSkid  = 1'b0;
        end
    end

    // Handshake outputs are registered from the next state so they leave flops directly.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= EMPTY;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
        end else begin
            state     <= stateNext;
            inReadyQ  <= (stateNext != FULL);
            outValidQ <= (stateNext != EMPTY);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mainData <= '0;
            skidData <= '0;
        end else begin
            if (loadMain)      mainData <= selData;
            else if (moveSkid) mainData <= skidData;
            if (loadSkid)      skidData <= selData;
        end
    end

    // A new error in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            SelErr   <= 1'b0;
            ErrCount <= '0;
        end else if (errHit) begin
            SelErr   <= 1'b1;
            if (ErrClr)                ErrCount <= 8'd1;
            else if (ErrCount != 8'hFF) ErrCount <= ErrCount + 8'd1;
        end else if (ErrClr) begin
            SelErr   <= 1'b0;
            ErrCount <= '0;
        end
    end

    assign InReady  = inReadyQ;
    assign OutValid = outValidQ;
    assign OutData  = mainData;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Bench for operand_mux_pipe: a 4-source and a 3-source instance share stimulus;
// outputs are checked against a queue of expected values plus directed corner sequences.
module tb_operand_mux_pipe;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [127:0] srcData;
    logic [1:0]   sel;
    logic         extMode, inValid, outReady, flush, errClr;

    logic         inReady4, outValid4, selErr4;
    logic [31:0]  outData4;
    logic [7:0]   errCount4;
    logic         inReady3, outValid3, selErr3;
    logic [31:0]  outData3;
    logic [7:0]   errCount3;

    typedef struct { logic [31:0] d4; logic [31:0] d3; } expT;
    typedef struct { logic [1:0] s; logic e; logic [31:0] src2; logic [31:0] e4; logic [31:0] e3; } vecT;

    expT         q[$];
    vecT         vecs[10];
    logic [31:0] curExp4, curExp3;
    int          nApplied = 0;
    int          nMiss = 0;
    int          errExp3 = 0;

    always #5 Clk = ~Clk;

    operand_mux_pipe u4 (
        .Clk(Clk), .Rst_n(Rst_n), .SrcData(srcData), .Sel(sel), .ExtMode(extMode),
        .InValid(inValid), .InReady(inReady4), .OutData(outData4), .OutValid(outValid4),
        .OutReady(outReady), .Flush(flush), .ErrClr(errClr), .SelErr(selErr4), .ErrCount(errCount4)
    );

    operand_mux_pipe #(.NSRC(3)) u3 (
        .Clk(Clk), .Rst_n(Rst_n), .SrcData(srcData[95:0]), .Sel(sel), .ExtMode(extMode),
        .InValid(inValid), .InReady(inReady3), .OutData(outData3), .OutValid(outValid3),
        .OutReady(outReady), .Flush(flush), .ErrClr(errClr), .SelErr(selErr3), .ErrCount(errCount3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] s, input logic e,
                                          input logic [31:0] s2, input int nsrc);
        case (s)
            2'd0:    return 32'h11111111;
            2'd1:    return 32'h22222222;
            2'd2:    return e ? {{16{s2[15]}}, s2[15:0]} : {16'h0000, s2[15:0]};
            default: return (nsrc == 4) ? 32'h44444444 : 32'h00000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] s, input logic e, input logic [31:0] s2);
        inValid = v;
        sel     = s;
        extMode = e;
        srcData = {32'h44444444, s2, 32'h22222222, 32'h11111111};
        curExp4 = model(s, e, s2, 4);
        curExp3 = model(s, e, s2, 3);
    endtask

    task automatic drain();
        for (int t = 0; t < 20; t++) begin
            if (q.size() == 0 && !outValid4) break;
            tick();
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: OutValid must track queue occupancy; the head must sit on OutData while valid.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            q.delete();
            errExp3 = 0;
        end else begin
            chk("outValid", 32'(outValid4), 32'(q.size() != 0));
            if (outValid4 && !flush && q.size() != 0) begin
                chk("out4", outData4, q[0].d4);
                chk("out3", outData3, q[0].d3);
                chk("valid3", 32'(outValid3), 32'd1);
                if (outReady) void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (inValid && inReady4) q.push_back('{curExp4, curExp3});
            if (inValid && inReady3 && !flush && sel == 2'd3)
                errExp3 = errClr ? 1 : ((errExp3 == 255) ? 255 : errExp3 + 1);
            else if (errClr)
                errExp3 = 0;
        end
    end

    initial begin
        int e3Before;
        logic accepted;

        vecs = '{
            '{2'd0, 1'b0, 32'h00008001, 32'h11111111, 32'h11111111},
            '{2'd1, 1'b0, 32'h00008001, 32'h22222222, 32'h22222222},
            '{2'd3, 1'b0, 32'h00008001, 32'h44444444, 32'h00000000},
            '{2'd2, 1'b1, 32'h00008001, 32'hFFFF8001, 32'hFFFF8001},
            '{2'd2, 1'b0, 32'h00008001, 32'h00008001, 32'h00008001},
            '{2'd2, 1'b1, 32'h12347FFF, 32'h00007FFF, 32'h00007FFF},
            '{2'd2, 1'b1, 32'hABCDF00F, 32'hFFFFF00F, 32'hFFFFF00F},
            '{2'd2, 1'b0, 32'hABCDF00F, 32'h0000F00F, 32'h0000F00F},
            '{2'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{2'd0, 1'b1, 32'hFFFFFFFF, 32'h11111111, 32'h11111111}
        };

        Rst_n = 1'b0; outReady = 1'b1; flush = 1'b0; errClr = 1'b0;
        drv(1'b0, 2'd0, 1'b0, 32'h0);
        repeat (2) tick();
        chk("rstOutValid", 32'(outValid4), 32'd0);
        chk("rstOutData", outData4, 32'd0);
        chk("rstInReady", 32'(inReady4), 32'd1);
        chk("rstSelErr", 32'(selErr3), 32'd0);
        chk("rstErrCount", 32'(errCount3), 32'd0);
        Rst_n = 1'b1;
        tick();

        // Back-to-back table with OutReady held: each result appears one edge after accept.
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, vecs[i].s, vecs[i].e, vecs[i].src2);
            curExp4 = vecs[i].e4;
            curExp3 = vecs[i].e3;
            tick();
            chk("tbl4", outData4, vecs[i].e4);
            chk("tbl3", outData3, vecs[i].e3);
            chk("tblInReady", 32'(inReady4), 32'd1);
        end
        inValid = 1'b0;
        drain();

        // Backpressure: A and B fill the buffer, C waits for InReady.
        outReady = 1'b0;
        drv(1'b1, 2'd0, 1'b0, 32'h0); tick();
        drv(1'b1, 2'd1, 1'b0, 32'h0); tick();
        chk("fullInReady", 32'(inReady4), 32'd0);
        drv(1'b1, 2'd3, 1'b0, 32'h0); tick();
        chk("holdA", outData4, 32'h11111111);
        chk("holdInReady", 32'(inReady4), 32'd0);
        tick();
        chk("holdA2", outData4, 32'h11111111);
        outReady = 1'b1;
        accepted = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge Clk);
            if (inReady4) begin accepted = 1'b1; break; end
        end
        tick();
        inValid = 1'b0;
        chk("cAccepted", 32'(accepted), 32'd1);
        drain();

        // Flush while FULL, with a same-cycle illegal input that must not be counted.
        outReady = 1'b0;
        drv(1'b1, 2'd0, 1'b0, 32'h0); tick();
        drv(1'b1, 2'd3, 1'b0, 32'h0); tick();
        e3Before = int'(errCount3);
        drv(1'b1, 2'd3, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0; inValid = 1'b0;
        chk("flushValid", 32'(outValid4), 32'd0);
        chk("flushValid3", 32'(outValid3), 32'd0);
        chk("flushInReady", 32'(inReady4), 32'd1);
        chk("flushErrCount", 32'(errCount3), 32'(e3Before));
        outReady = 1'b1;
        repeat (5) tick();
        chk("flushQuiet", 32'(outValid4), 32'd0);

        // Error saturation on the 3-source instance.
        errClr = 1'b1; tick(); errClr = 1'b0;
        chk("clrSelErr", 32'(selErr3), 32'd0);
        chk("clrErrCount", 32'(errCount3), 32'd0);
        for (int i = 0; i < 300; i++) begin
            drv(1'b1, 2'd3, 1'b0, 32'h0);
            tick();
            if (i == 99) chk("errCount100", 32'(errCount3), 32'd100);
        end
        inValid = 1'b0;
        chk("errSat", 32'(errCount3), 32'd255);
        chk("selErrSet", 32'(selErr3), 32'd1);
        chk("noErr4", 32'(errCount4), 32'd0);
        chk("noSelErr4", 32'(selErr4), 32'd0);
        drv(1'b1, 2'd3, 1'b0, 32'h0);
        errClr = 1'b1; tick(); errClr = 1'b0; inValid = 1'b0;
        chk("clrVsErrCount", 32'(errCount3), 32'd1);
        chk("clrVsSelErr", 32'(selErr3), 32'd1);
        errClr = 1'b1; tick(); errClr = 1'b0;
        chk("clrAgain", 32'(errCount3), 32'd0);
        drain();

        // Random traffic, stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            tick();
        end
        inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
        drain();
        chk("rndErrCount", 32'(errCount3), 32'(errExp3));

        // Asynchronous reset in the middle of a cycle while FULL.
        outReady = 1'b0;
        drv(1'b1, 2'd3, 1'b0, 32'h0); tick();
        drv(1'b1, 2'd3, 1'b0, 32'h0); tick();
        inValid = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        chk("arstValid", 32'(outValid4), 32'd0);
        chk("arstData", outData4, 32'd0);
        chk("arstErrCount", 32'(errCount3), 32'd0);
        chk("arstInReady", 32'(inReady4), 32'd1);
        tick();
        Rst_n = 1'b1; outReady = 1'b1;
        drv(1'b1, 2'd1, 1'b0, 32'h0);
        tick();
        inValid = 1'b0;
        chk("postRstValid", 32'(outValid4), 32'd1);
        chk("postRstData", outData4, 32'h22222222);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
